// File: rtl/vec_pkg.sv
// Shared types and width helpers for the weight/input dot-product stream.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT,
    DONE
  } state_e;

  // Worst case is d full-scale products summed: d * (2^n - 1)^2 < (d + 1) * 2^(2n).
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned d);
    return 2 * n + $clog2(d + 1);
  endfunction

  // Width of a counter that indexes 0..n-1, kept at least 1 bit wide.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_mac.sv
// Registered multiply-accumulate: clr_load starts a fresh sum, en adds to it.
module vec_mac #(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_load,
  input  logic             en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc_q;

  assign prod = ACC_W'(a) * ACC_W'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_load) begin
      acc_q <= prod;
    end else if (en) begin
      acc_q <= acc_q + prod;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/vec_dot_stream.sv
// Streams Q vector pairs of D elements, one element pair per beat, and emits one
// unsigned dot product per pair with its index over a valid/ready output.
module vec_dot_stream
  import vec_pkg::*;
#(
  parameter int unsigned Q      = 100,
  parameter int unsigned D      = 3,
  parameter int unsigned N      = 16,
  localparam int unsigned ACC_W = acc_width(N, D),
  localparam int unsigned QW    = cnt_width(Q),
  localparam int unsigned DW    = cnt_width(D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     w_in,
  input  logic [N-1:0]     x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] dot_out,
  output logic [QW-1:0]    vec_idx,
  output logic             busy,
  output logic             done
);

  state_e        state_q, state_d;
  logic [DW-1:0] elem_q, elem_d;
  logic [QW-1:0] vec_q, vec_d;
  logic          mac_clr, mac_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    vec_d     = vec_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          elem_d  = '0;
          vec_d   = '0;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First element overwrites the accumulator so no earlier sum leaks in.
          mac_clr = (elem_q == '0);
          mac_en  = (elem_q != '0);
          if (elem_q == DW'(D - 1)) begin
            elem_d  = '0;
            state_d = EMIT;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (vec_q == QW'(Q - 1)) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The accumulator holds the final sum untouched throughout EMIT.
  vec_mac #(
    .N    (N),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_load(mac_clr),
    .en      (mac_en),
    .a       (w_in),
    .b       (x_in),
    .acc     (dot_out)
  );

  assign vec_idx = vec_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vec_dot_stream.sv
// Directed plus randomized bench for vec_dot_stream against an arithmetic dot-product model.
module tb_vec_dot_stream;

  localparam int unsigned Q     = 100;
  localparam int unsigned D     = 3;
  localparam int unsigned N     = 16;
  localparam int unsigned ACC_W = 34;
  localparam int unsigned QW    = 7;

  typedef logic [N-1:0] vec_t [D];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [N-1:0]     w_in = '0;
  logic [N-1:0]     x_in = '0;
  logic             in_ready, out_valid, busy, done;
  logic [ACC_W-1:0] dot_out;
  logic [QW-1:0]    vec_idx;

  int total = 0;
  int bad = 0;

  vec_t            wb [Q];
  vec_t            xb [Q];
  longint unsigned expb [Q];

  vec_dot_stream #(
    .Q(Q),
    .D(D),
    .N(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_in     (w_in),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dot_out  (dot_out),
    .vec_idx  (vec_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned model_dot(input vec_t w, input vec_t x);
    longint unsigned s = 0;
    for (int j = 0; j < D; j++) s += 64'(w[j]) * 64'(x[j]);
    return s;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < D; j++) v[j] = N'($urandom);
    return v;
  endfunction

  task automatic send_elem(input logic [N-1:0] w, input logic [N-1:0] x, input int bubbles);
    logic got = 1'b0;
    in_valid = 1'b0;
    repeat (bubbles) step();
    in_valid = 1'b1;
    w_in = w;
    x_in = x;
    for (int k = 0; k < 50 && !got; k++) begin
      if (in_ready) got = 1'b1;
      step();
    end
    check("beat_accepted", 64'(got), 64'd1);
    in_valid = 1'b0;
    w_in = N'($urandom);
    x_in = N'($urandom);
  endtask

  task automatic send_vec(input vec_t w, input vec_t x, input bit bubbly);
    for (int j = 0; j < D; j++) begin
      send_elem(w[j], x[j], (bubbly && $urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
    end
  endtask

  task automatic take_result(input longint unsigned exp_dot, input int exp_idx, input string tag);
    for (int k = 0; k < 50 && !out_valid; k++) step();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_dot"}, 64'(dot_out), exp_dot);
    check({tag, "_idx"}, 64'(vec_idx), 64'(exp_idx));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outs"}, {59'd0, in_ready, out_valid, busy, done, 1'b0}, 64'd0);
    check({tag, "_dot"}, 64'(dot_out), 64'd0);
    check({tag, "_idx"}, 64'(vec_idx), 64'd0);
  endtask

  task automatic check_done_pulse(input string tag);
    check({tag, "_done_hi"}, 64'(done), 64'd1);
    check({tag, "_busy_hi"}, 64'(busy), 64'd1);
    check({tag, "_ov_lo"}, 64'(out_valid), 64'd0);
    // A start seen during DONE must not launch a new run.
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_done_lo"}, 64'(done), 64'd0);
    check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    step();
    check({tag, "_stay_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t w, x;
    longint unsigned e;
    int seed_w = 1;
    int seed_x = 2;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_wait", 64'(busy), 64'd0);

    // Full run from seeded generators, no bubbles.
    for (int v = 0; v < Q; v++) begin
      for (int j = 0; j < D; j++) begin
        wb[v][j] = N'($random(seed_w));
        xb[v][j] = N'($random(seed_x));
      end
      expb[v] = model_dot(wb[v], xb[v]);
    end
    do_start();
    for (int v = 0; v < Q; v++) begin
      send_vec(wb[v], xb[v], 1'b0);
      take_result(expb[v], v, "full");
    end
    check_done_pulse("full");

    // Directed vectors, back-pressure, then the same data with bubbles.
    do_start();
    w = '{16'd1, 16'd2, 16'd3};
    x = '{16'd4, 16'd5, 16'd6};
    send_vec(w, x, 1'b0);
    check("t1_latency", 64'(out_valid), 64'd1);
    take_result(64'd32, 0, "t1");

    w = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    take_result_after_send: begin
      send_vec(w, w, 1'b0);
      take_result(64'h2_FFFA_0003, 1, "t2");
    end

    w = rand_vec();
    x = rand_vec();
    e = model_dot(w, x);
    send_vec(w, x, 1'b0);
    repeat (5) begin
      step();
      check("t3_in_ready", 64'(in_ready), 64'd0);
      check("t3_out_valid", 64'(out_valid), 64'd1);
      check("t3_dot_hold", 64'(dot_out), e);
      check("t3_idx_hold", 64'(vec_idx), 64'd2);
    end
    take_result(e, 2, "t3");
    check("t3_back_to_accum", 64'(in_ready), 64'd1);

    for (int v = 3; v < Q; v++) begin
      start = (v == 5);
      send_vec(wb[v], xb[v], 1'b1);
      start = 1'b0;
      take_result(expb[v], v, "bubbly");
    end
    check_done_pulse("bubbly");

    // Asynchronous reset one element into vector 40.
    do_start();
    for (int v = 0; v < 40; v++) begin
      send_vec(wb[v], xb[v], 1'b0);
      take_result(expb[v], v, "pre_rst");
    end
    send_elem(wb[40][0], xb[40][0], 0);
    check("pre_rst_idx", 64'(vec_idx), 64'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 64'(busy), 64'd0);
    do_start();
    w = rand_vec();
    x = rand_vec();
    send_vec(w, x, 1'b0);
    take_result(model_dot(w, x), 0, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
